// File: rtl/dfx_stream_pkg.sv
// Shared definitions for the DFX stream decoupler: FSM encoding and counter width.
package dfx_stream_pkg;

  typedef enum logic [1:0] {
    ST_PASS      = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_DECOUPLED = 2'd2
  } dfx_state_e;

  localparam int BEAT_COUNT_WIDTH = 32;

endpackage : dfx_stream_pkg

// File: rtl/stream_decouple_ctrl.sv
// AXI-Stream decoupler for a reconfigurable partition. Passes the stream through
// with zero latency, drains any open packet when isolation is requested, and
// forces isolation (flagging timeout_err) if the drain stalls too long.
module stream_decouple_ctrl
  import dfx_stream_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       S_AXI_TDATA,
  input  logic [DATA_WIDTH/8-1:0]     S_AXI_TKEEP,
  input  logic                        S_AXI_TVALID,
  output logic                        S_AXI_TREADY,
  input  logic                        S_AXI_TLAST,
  output logic [DATA_WIDTH-1:0]       M_AXI_TDATA,
  output logic [DATA_WIDTH/8-1:0]     M_AXI_TKEEP,
  output logic                        M_AXI_TVALID,
  input  logic                        M_AXI_TREADY,
  output logic                        M_AXI_TLAST,
  input  logic                        decouple_req,
  input  logic [TIMEOUT_WIDTH-1:0]    timeout_limit,
  output logic                        decouple_ack,
  output logic                        timeout_err,
  input  logic                        err_clr,
  output logic [BEAT_COUNT_WIDTH-1:0] beat_count
);

  dfx_state_e                  state_q, state_d;
  logic                        in_pkt_q, in_pkt_d;
  logic [TIMEOUT_WIDTH-1:0]    drain_cnt_q, drain_cnt_d;
  logic                        ack_q;
  logic                        timeout_err_q;
  logic [BEAT_COUNT_WIDTH-1:0] beat_count_q;
  logic                        pass_s;
  logic                        accept_s;
  logic                        timeout_hit_s;

  // Pass/block decision and the combinational stream path; reset always blocks.
  always_comb begin
    pass_s = 1'b0;
    if (reset) begin
      pass_s = 1'b0;
    end else begin
      case (state_q)
        ST_PASS:      pass_s = 1'b1;
        ST_DRAIN:     pass_s = in_pkt_q;
        ST_DECOUPLED: pass_s = 1'b0;
        default:      pass_s = 1'b0;
      endcase
    end
    M_AXI_TDATA  = S_AXI_TDATA;
    M_AXI_TKEEP  = S_AXI_TKEEP;
    M_AXI_TLAST  = S_AXI_TLAST;
    M_AXI_TVALID = pass_s & S_AXI_TVALID;
    S_AXI_TREADY = pass_s & M_AXI_TREADY;
    accept_s     = S_AXI_TVALID & S_AXI_TREADY;
  end

  // Next state, packet tracking and drain-timeout detection.
  always_comb begin
    state_d       = state_q;
    in_pkt_d      = in_pkt_q;
    timeout_hit_s = 1'b0;
    if (accept_s) begin
      in_pkt_d = ~S_AXI_TLAST;
    end else begin
      in_pkt_d = in_pkt_q;
    end
    case (state_q)
      ST_PASS: begin
        if (decouple_req) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_PASS;
        end
      end
      ST_DRAIN: begin
        if (!decouple_req) begin
          state_d = ST_PASS;
        end else if (!in_pkt_d) begin
          // Packet boundary reached (possibly on this very edge's TLAST beat).
          state_d = ST_DECOUPLED;
        end else if ((timeout_limit != {TIMEOUT_WIDTH{1'b0}}) &&
                     (drain_cnt_q == (timeout_limit - TIMEOUT_WIDTH'(1)))) begin
          // Drain stalled: abandon the packet and isolate anyway.
          state_d       = ST_DECOUPLED;
          in_pkt_d      = 1'b0;
          timeout_hit_s = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DECOUPLED: begin
        if (!decouple_req) begin
          state_d = ST_PASS;
        end else begin
          state_d = ST_DECOUPLED;
        end
      end
      default: begin
        state_d  = ST_PASS;
        in_pkt_d = 1'b0;
      end
    endcase
  end

  // Drain cycle counter: reload on DRAIN entry, count in DRAIN, hold otherwise.
  always_comb begin
    drain_cnt_d = drain_cnt_q;
    if ((state_q != ST_DRAIN) && (state_d == ST_DRAIN)) begin
      drain_cnt_d = {TIMEOUT_WIDTH{1'b0}};
    end else if (state_q == ST_DRAIN) begin
      drain_cnt_d = drain_cnt_q + TIMEOUT_WIDTH'(1);
    end else begin
      drain_cnt_d = drain_cnt_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PASS;
    end else begin
      state_q <= state_d;
    end
  end

  // Packet flag, drain counter, status flags and beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_pkt_q      <= 1'b0;
      drain_cnt_q   <= {TIMEOUT_WIDTH{1'b0}};
      ack_q         <= 1'b0;
      timeout_err_q <= 1'b0;
      beat_count_q  <= {BEAT_COUNT_WIDTH{1'b0}};
    end else begin
      in_pkt_q    <= in_pkt_d;
      drain_cnt_q <= drain_cnt_d;
      ack_q       <= (state_d == ST_DECOUPLED);
      if (timeout_hit_s) begin
        timeout_err_q <= 1'b1;
      end else if (err_clr) begin
        timeout_err_q <= 1'b0;
      end
      if (accept_s) begin
        beat_count_q <= beat_count_q + BEAT_COUNT_WIDTH'(1);
      end
    end
  end

  assign decouple_ack = ack_q;
  assign timeout_err  = timeout_err_q;
  assign beat_count   = beat_count_q;

endmodule : stream_decouple_ctrl

// File: tb/tb_stream_decouple_ctrl.sv
// Directed self-checking bench for stream_decouple_ctrl.
module tb_stream_decouple_ctrl;

  localparam int DW = 32;
  localparam int TW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   s_tdata;
  logic [DW/8-1:0] s_tkeep;
  logic            s_tvalid;
  logic            s_tready;
  logic            s_tlast;
  logic [DW-1:0]   m_tdata;
  logic [DW/8-1:0] m_tkeep;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic            decouple_req;
  logic [TW-1:0]   timeout_limit;
  logic            decouple_ack;
  logic            timeout_err;
  logic            err_clr;
  logic [31:0]     beat_count;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  logic [31:0] exp_beats = 32'd0;

  stream_decouple_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .S_AXI_TDATA(s_tdata), .S_AXI_TKEEP(s_tkeep), .S_AXI_TVALID(s_tvalid),
    .S_AXI_TREADY(s_tready), .S_AXI_TLAST(s_tlast),
    .M_AXI_TDATA(m_tdata), .M_AXI_TKEEP(m_tkeep), .M_AXI_TVALID(m_tvalid),
    .M_AXI_TREADY(m_tready), .M_AXI_TLAST(m_tlast),
    .decouple_req(decouple_req), .timeout_limit(timeout_limit),
    .decouple_ack(decouple_ack), .timeout_err(timeout_err),
    .err_clr(err_clr), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat that must pass through and be accepted on the next edge.
  task automatic send_beat(input string tag, input logic [31:0] data, input logic last);
    s_tdata  = data;
    s_tkeep  = data[3:0];
    s_tlast  = last;
    s_tvalid = 1'b1;
    #1;
    check({tag, " m_tvalid"}, m_tvalid, 1'b1);
    check({tag, " s_tready"}, s_tready, 1'b1);
    check({tag, " m_tdata"},  m_tdata,  data);
    check({tag, " m_tkeep"},  m_tkeep,  data[3:0]);
    check({tag, " m_tlast"},  m_tlast,  last);
    tick();
    exp_beats = exp_beats + 32'd1;
    s_tvalid  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; s_tdata = 32'h0; s_tkeep = 4'h0; s_tvalid = 1'b1; s_tlast = 1'b0;
    m_tready = 1'b1; decouple_req = 1'b0; timeout_limit = 16'd0; err_clr = 1'b0;
    tick(); tick();
    // Reset blocks the stream and clears status.
    check("rst s_tready", s_tready, 1'b0);
    check("rst m_tvalid", m_tvalid, 1'b0);
    check("rst ack", decouple_ack, 1'b0);
    check("rst err", timeout_err, 1'b0);
    check("rst beats", beat_count, 32'd0);
    s_tvalid = 1'b0;
    reset = 1'b0;
    tick();

    // Idle pass-through, 4 beats.
    send_beat("p1b1", 32'hA000_0001, 1'b0);
    send_beat("p1b2", 32'hA000_0002, 1'b0);
    send_beat("p1b3", 32'hA000_0003, 1'b0);
    send_beat("p1b4", 32'hA000_0004, 1'b1);
    check("p1 beats", beat_count, 32'd4);
    check("p1 ack", decouple_ack, 1'b0);

    // Drain at packet boundary: request raised alongside beat 3 of 5.
    send_beat("p2b1", 32'hB000_0001, 1'b0);
    send_beat("p2b2", 32'hB000_0002, 1'b0);
    decouple_req = 1'b1;
    send_beat("p2b3", 32'hB000_0003, 1'b0);
    check("p2 ack in drain", decouple_ack, 1'b0);
    send_beat("p2b4", 32'hB000_0004, 1'b0);
    send_beat("p2b5", 32'hB000_0005, 1'b1);
    check("p2 ack after last", decouple_ack, 1'b1);
    s_tdata = 32'hC0DE_0001; s_tvalid = 1'b1; s_tlast = 1'b0;
    #1;
    check("p2 blocked s_tready", s_tready, 1'b0);
    check("p2 blocked m_tvalid", m_tvalid, 1'b0);
    check("p2 blocked mirror", m_tdata, 32'hC0DE_0001);
    tick();
    check("p2 beats", beat_count, 32'd9);
    s_tvalid = 1'b0;

    // Recouple: drop request, ready follows downstream again.
    decouple_req = 1'b0;
    tick();
    check("rc ack", decouple_ack, 1'b0);
    check("rc s_tready hi", s_tready, 1'b1);
    m_tready = 1'b0;
    #1;
    check("rc s_tready lo", s_tready, 1'b0);
    m_tready = 1'b1;
    send_beat("rcb1", 32'hD000_0001, 1'b0);
    send_beat("rcb2", 32'hD000_0002, 1'b0);
    send_beat("rcb3", 32'hD000_0003, 1'b1);
    check("rc beats", beat_count, 32'd12);

    // Request withdrawn mid-drain: packet completes, ack never rises.
    send_beat("wdb1", 32'hE000_0001, 1'b0);
    decouple_req = 1'b1;
    tick();
    check("wd drain ready", s_tready, 1'b1);
    check("wd ack1", decouple_ack, 1'b0);
    tick();
    check("wd ack2", decouple_ack, 1'b0);
    tick();
    check("wd ack3", decouple_ack, 1'b0);
    decouple_req = 1'b0;
    tick();
    check("wd ack4", decouple_ack, 1'b0);
    send_beat("wdb2", 32'hE000_0002, 1'b0);
    send_beat("wdb3", 32'hE000_0003, 1'b1);
    check("wd beats", beat_count, 32'd15);
    check("wd ack5", decouple_ack, 1'b0);

    // Drain timeout with downstream stalled mid-packet.
    timeout_limit = 16'd8;
    send_beat("tob1", 32'hF000_0001, 1'b0);
    m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hF000_0002; decouple_req = 1'b1;
    tick();                                   // enter DRAIN, count 0
    for (int i = 0; i < 7; i++) tick();       // counts 1..7
    check("to ack before", decouple_ack, 1'b0);
    check("to err before", timeout_err, 1'b0);
    tick();                                   // edge at count 7 forces DECOUPLED
    check("to ack", decouple_ack, 1'b1);
    check("to err", timeout_err, 1'b1);
    m_tready = 1'b1;
    #1;
    check("to blocked", s_tready, 1'b0);
    tick(); tick();
    check("to err sticky", timeout_err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to err cleared", timeout_err, 1'b0);
    check("to beats", beat_count, 32'd16);
    s_tvalid = 1'b0;
    decouple_req = 1'b0;
    timeout_limit = 16'd0;
    tick();
    check("to recoupled", s_tready, 1'b1);

    // Reset in the middle of a drain abandons the packet.
    send_beat("rsb1", 32'h1234_5678, 1'b0);
    m_tready = 1'b0; decouple_req = 1'b1;
    tick();
    check("rs pre beats", beat_count, exp_beats);
    reset = 1'b1; decouple_req = 1'b0;
    tick();
    reset = 1'b0; m_tready = 1'b1;
    check("rs ack", decouple_ack, 1'b0);
    check("rs err", timeout_err, 1'b0);
    check("rs beats", beat_count, 32'd0);
    #1;
    check("rs pass state", s_tready, 1'b1);
    decouple_req = 1'b1;
    tick();                                   // DRAIN with no open packet
    check("rs in_pkt clear", s_tready, 1'b0);
    tick();
    check("rs quick decouple", decouple_ack, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_stream_decouple_ctrl
